// File: rtl/ser_4_to_2.sv
// 4-bit to 2-bit serializer with a one-entry input buffer and a registered IDLE/LO/HI engine.
// Optional underflow counter on o_uflow_cnt is enabled by defining SER_4_TO_2_UFLOW_CNT_EN.
module ser_4_to_2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_dat,
    input  logic       i_vld,
    output logic       o_rdy,
    output logic [1:0] o_dat,
    output logic       o_vld,
    output logic       o_frame
`ifdef SER_4_TO_2_UFLOW_CNT_EN
    ,
    output logic [7:0] o_uflow_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    state_t     state_q, state_d;
    logic       buf_vld_q, buf_vld_d;
    logic [3:0] buf_dat_q, buf_dat_d;
    logic [1:0] shift_q, shift_d;
    logic [1:0] dat_q, dat_d;
    logic       vld_q, vld_d;
    logic       frame_q, frame_d;
    logic       rdy_q, rdy_d;
    logic       accept;
    logic       load;

`ifdef SER_4_TO_2_UFLOW_CNT_EN
    logic [7:0] uflow_q, uflow_d;
`endif

    always_comb begin
        state_d   = state_q;
        buf_vld_d = buf_vld_q;
        buf_dat_d = buf_dat_q;
        shift_d   = shift_q;
        dat_d     = dat_q;
        vld_d     = vld_q;
        frame_d   = frame_q;

        accept = i_vld && rdy_q;
        load   = (state_q != LO) && buf_vld_q && i_en;

        // Accept needs an empty buffer and load needs a full one, so they never collide.
        if (accept) begin
            buf_vld_d = 1'b1;
            buf_dat_d = i_dat;
        end else if (load) begin
            buf_vld_d = 1'b0;
        end

        case (state_q)
            LO: begin
                state_d = HI;
                dat_d   = shift_q;
                vld_d   = 1'b1;
                frame_d = 1'b0;
            end
            default: begin
                if (load) begin
                    state_d = LO;
                    shift_d = buf_dat_q[3:2];
                    dat_d   = buf_dat_q[1:0];
                    vld_d   = 1'b1;
                    frame_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    dat_d   = 2'b00;
                    vld_d   = 1'b0;
                    frame_d = 1'b0;
                end
            end
        endcase

        rdy_d = !buf_vld_d;
    end

`ifdef SER_4_TO_2_UFLOW_CNT_EN
    // A stream gap while enabled: finishing a word with nothing ready to follow.
    always_comb begin
        uflow_d = uflow_q;
        if ((state_q == HI) && !load && i_en && (uflow_q != 8'hFF)) begin
            uflow_d = uflow_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            buf_vld_q <= 1'b0;
            buf_dat_q <= 4'h0;
            shift_q   <= 2'b00;
            dat_q     <= 2'b00;
            vld_q     <= 1'b0;
            frame_q   <= 1'b0;
            rdy_q     <= 1'b1;
`ifdef SER_4_TO_2_UFLOW_CNT_EN
            uflow_q   <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            buf_vld_q <= buf_vld_d;
            buf_dat_q <= buf_dat_d;
            shift_q   <= shift_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            frame_q   <= frame_d;
            rdy_q     <= rdy_d;
`ifdef SER_4_TO_2_UFLOW_CNT_EN
            uflow_q   <= uflow_d;
`endif
        end
    end

    assign o_rdy   = rdy_q;
    assign o_dat   = dat_q;
    assign o_vld   = vld_q;
    assign o_frame = frame_q;
`ifdef SER_4_TO_2_UFLOW_CNT_EN
    assign o_uflow_cnt = uflow_q;
`endif

endmodule

// File: tb/tb_ser_4_to_2.sv
// Self-checking bench for ser_4_to_2: directed scenarios plus random traffic against a word-level model.
// Underflow counter checks are compiled only when SER_4_TO_2_UFLOW_CNT_EN is defined.
module tb_ser_4_to_2;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_dat;
    logic       i_vld;
    logic       o_rdy;
    logic [1:0] o_dat;
    logic       o_vld;
    logic       o_frame;
`ifdef SER_4_TO_2_UFLOW_CNT_EN
    logic [7:0] o_uflow_cnt;
`endif

    always #5 i_clk = ~i_clk;

    ser_4_to_2 dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_dat   (i_dat),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_vld   (o_vld),
        .o_frame (o_frame)
`ifdef SER_4_TO_2_UFLOW_CNT_EN
        ,
        .o_uflow_cnt (o_uflow_cnt)
`endif
    );

    localparam int KIND_IDLE   = 0;
    localparam int KIND_FIRST  = 1;
    localparam int KIND_SECOND = 2;

    int checks   = 0;
    int failures = 0;

    // Word-level model: queue of expected output chunks {frame, dat}, buffered word count,
    // what the previous output cycle carried, and the expected underflow count.
    logic [2:0] chunkQ[$];
    int         held       = 0;
    int         prevKind   = KIND_IDLE;
    int         uflowModel = 0;
    logic       lastAccept = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then compare every output with the model.
    task automatic applyStimulus(input logic rst, input logic en, input logic vld, input logic [3:0] dat);
        logic       acceptNow;
        logic [2:0] exp;
        i_rst = rst;
        i_en  = en;
        i_vld = vld;
        i_dat = dat;
        acceptNow = !rst && vld && (o_rdy === 1'b1);
        lastAccept = acceptNow;
        @(posedge i_clk);
        #1;
        if (rst) begin
            chunkQ.delete();
            held       = 0;
            prevKind   = KIND_IDLE;
            uflowModel = 0;
            checkOutput("rstVld", o_vld, 0);
            checkOutput("rstFrame", o_frame, 0);
            checkOutput("rstDat", o_dat, 0);
        end else begin
            if (prevKind == KIND_FIRST || (held > 0 && en)) begin
                if (prevKind != KIND_FIRST) begin
                    held--;
                end
                exp = (chunkQ.size() > 0) ? chunkQ.pop_front() : 3'b000;
                checkOutput("vld", o_vld, 1);
                checkOutput("frame", o_frame, exp[2]);
                checkOutput("dat", o_dat, exp[1:0]);
                prevKind = (prevKind == KIND_FIRST) ? KIND_SECOND : KIND_FIRST;
            end else begin
                if (prevKind == KIND_SECOND && en && uflowModel < 255) begin
                    uflowModel++;
                end
                prevKind = KIND_IDLE;
                checkOutput("idleVld", o_vld, 0);
                checkOutput("idleFrame", o_frame, 0);
                checkOutput("idleDat", o_dat, 0);
            end
            if (acceptNow) begin
                held++;
                chunkQ.push_back({1'b1, dat[1:0]});
                chunkQ.push_back({1'b0, dat[3:2]});
            end
        end
        checkOutput("rdy", o_rdy, (held == 0) ? 1 : 0);
`ifdef SER_4_TO_2_UFLOW_CNT_EN
        checkOutput("uflowCnt", o_uflow_cnt, uflowModel);
`endif
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] words[4];
        logic [1:0] expStream[6];
        logic [1:0] got[$];
        int         k;
        int         gaps;
        logic       started;

        i_rst = 1'b1;
        i_en  = 1'b0;
        i_vld = 1'b0;
        i_dat = 4'h0;

        // Single word 4'b1001.
        applyStimulus(1, 1, 0, 4'h0);
        checkOutput("resetRdy", o_rdy, 1);
        applyStimulus(0, 1, 1, 4'b1001);
        checkOutput("singleRdy", o_rdy, 0);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("singleLo", {o_vld, o_frame, o_dat}, 4'b1101);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("singleHi", {o_vld, o_frame, o_dat}, 4'b1010);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("singleEnd", o_vld, 0);

        // Streaming A, 5, F with i_vld held high.
        applyStimulus(1, 1, 0, 4'h0);
        words     = '{4'hA, 4'h5, 4'hF, 4'h0};
        expStream = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
        k = 0;
        gaps = 0;
        started = 1'b0;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            applyStimulus(0, 1, (k < 3), words[(k < 3) ? k : 3]);
            if (lastAccept) k++;
            if (o_vld) begin
                got.push_back(o_dat);
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
        end
        checkOutput("streamLen", got.size(), 6);
        checkOutput("streamGaps", gaps, 0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("streamDat", (i < got.size()) ? got[i] : 2'bxx, expStream[i]);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 4'h0);

        // Backpressure: 4'h3 captured, 4'hC offered while blocked.
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(0, 0, 1, 4'h3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 4'hC);
            checkOutput("bpBlocked", o_rdy, 0);
        end
        got.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 4'h0);
            if (o_vld) got.push_back(o_dat);
        end
        checkOutput("bpLen", got.size(), 2);
        checkOutput("bpFirst", (got.size() > 0) ? got[0] : 2'bxx, 2'b11);
        checkOutput("bpSecond", (got.size() > 1) ? got[1] : 2'bxx, 2'b00);

        // Enable drop during LO of 4'h6 while 4'h9 is captured.
        applyStimulus(1, 1, 0, 4'h0);
        applyStimulus(0, 1, 1, 4'h6);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("enLo", {o_vld, o_frame, o_dat}, 4'b1110);
        applyStimulus(0, 0, 1, 4'h9);
        checkOutput("enHi", {o_vld, o_frame, o_dat}, 4'b1001);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 4'h0);
            checkOutput("enHeld", o_vld, 0);
        end
`ifdef SER_4_TO_2_UFLOW_CNT_EN
        checkOutput("enNoUflow", o_uflow_cnt, 0);
`endif
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("enResumeLo", {o_vld, o_frame, o_dat}, 4'b1101);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("enResumeHi", {o_vld, o_frame, o_dat}, 4'b1010);

        // Reset during LO of 4'hE with 4'h1 offered on the reset edge.
        applyStimulus(1, 1, 0, 4'h0);
        applyStimulus(0, 1, 1, 4'hE);
        applyStimulus(0, 1, 0, 4'h0);
        checkOutput("rmLo", {o_vld, o_frame, o_dat}, 4'b1110);
        applyStimulus(1, 1, 1, 4'h1);
        checkOutput("rmAfter", {o_rdy, o_vld, o_dat}, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 4'h0);
            checkOutput("rmQuiet", o_vld, 0);
        end

`ifdef SER_4_TO_2_UFLOW_CNT_EN
        // 300 isolated words saturate the underflow counter.
        applyStimulus(1, 1, 0, 4'h0);
        for (int w = 0; w < 300; w++) begin
            applyStimulus(0, 1, 1, 4'($urandom));
            for (int g = 0; g < 4; g++) applyStimulus(0, 1, 0, 4'h0);
        end
        checkOutput("uflowSat", o_uflow_cnt, 255);
`endif

        // Random traffic.
        applyStimulus(1, 1, 0, 4'h0);
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) != 0),
                          1'($urandom), 4'($urandom));
        end

        // Drain anything still in flight.
        for (int c = 0; c < 10 && chunkQ.size() > 0; c++) begin
            applyStimulus(0, 1, 0, 4'h0);
        end
        checkOutput("drained", chunkQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
